// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// This block is the pipelined immediate generator that sits between decode
// and execute. It decodes the immediate of a RISC-V instruction word for the
// format picked by a one-hot select. It also forms the PC-relative target
// pc + imm. The result passes through a 2-entry skid buffer, which has a
// valid/ready handshake on each side.
//
// Parameters
//   XLEN       datapath width (32 or 64)
//   OP_W       width of the one-hot format select (at least 8)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      synchronous flush; drops every buffered entry
//   in_valid   upstream offers an instruction
//   in_ready   block can accept (registered, independent of out_ready)
//   inst       raw 32-bit instruction word
//   ext_op     one-hot format: 0 J, 1 U, 2 B, 3 S, 4 I, 5 ISHAMT, 6 CSRZ
//   pc         PC of the instruction
//   out_valid  head entry holds a result
//   out_ready  downstream accepts the head entry
//   imm        extended immediate of the head entry
//   target     pc + imm (mod 2^XLEN) of the head entry
//   op_err     ext_op of the head entry was not exactly one of bits 0..6
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int OP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [OP_W-1:0] ext_op,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            op_err
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Immediate extraction (combinational, at the input side)
    // -----------------------------------------------------------------------
    logic signed [11:0] i_raw;
    logic signed [11:0] s_raw;
    logic signed [12:0] b_raw;
    logic signed [31:0] u_raw;
    logic signed [20:0] j_raw;
    logic               op_ok;
    logic [XLEN-1:0]    imm_c;
    entry_t             new_entry;

    // The opcode field never feeds an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    assign i_raw = inst[31:20];
    assign s_raw = {inst[31:25], inst[11:7]};
    assign b_raw = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_raw = {inst[31:12], 12'b0};
    assign j_raw = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Legal only when exactly one of bits 0..6 is set and nothing above bit 6.
    assign op_ok = $onehot(ext_op[6:0]) && ((ext_op >> 7) == '0);

    always_comb begin
        // NOTE: the default assignment comes first, so every path through this
        // block drives imm_c and no latch is inferred.
        imm_c = '0;
        if (op_ok) begin
            // A size cast of a signed operand sign-extends it. A size cast of
            // an unsigned operand zero-extends it.
            if (ext_op[0])      imm_c = XLEN'(j_raw);
            else if (ext_op[1]) imm_c = XLEN'(u_raw);
            else if (ext_op[2]) imm_c = XLEN'(b_raw);
            else if (ext_op[3]) imm_c = XLEN'(s_raw);
            else if (ext_op[4]) imm_c = XLEN'(i_raw);
            else if (ext_op[5]) imm_c = (XLEN == 64) ? XLEN'(inst[25:20])
                                                     : XLEN'(inst[24:20]);
            else                imm_c = XLEN'(inst[19:15]);
        end
    end

    assign new_entry.imm    = imm_c;
    assign new_entry.target = pc + imm_c;  // wraps modulo 2^XLEN
    assign new_entry.err    = !op_ok;

    // -----------------------------------------------------------------------
    // 2-entry in-order buffer: head_q is always the oldest entry
    // -----------------------------------------------------------------------
    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   in_ready_q;
    logic   push;
    logic   pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_entry;  // old head leaves, new one takes over
                end else if (push) begin
                    tail_d  = new_entry;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // register samples the values from before the edge.
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // NOTE: tail_q is left out of reset. It is read only after a push has
    // written it, so clearing it would add reset fan-out for no benefit.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    // Gating with rst holds in_ready low while reset is asserted. in_ready
    // still has no path from out_ready.
    assign in_ready  = in_ready_q && !rst;
    assign out_valid = (state_q != EMPTY);
    assign imm       = head_q.imm;
    assign target    = head_q.target;
    assign op_err    = head_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. It uses two instances: XLEN=32 and XLEN=64.
// When an input is accepted, its expected result goes into a per-instance
// queue. When the DUT hands an entry downstream, the result is popped from
// that queue and compared.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] target;
        logic        err;
    } exp_t;

    localparam logic [7:0] OP_J  = 8'h01;
    localparam logic [7:0] OP_U  = 8'h02;
    localparam logic [7:0] OP_B  = 8'h04;
    localparam logic [7:0] OP_S  = 8'h08;
    localparam logic [7:0] OP_I  = 8'h10;
    localparam logic [7:0] OP_SH = 8'h20;
    localparam logic [7:0] OP_CZ = 8'h40;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    // XLEN = 32 instance
    logic        in_valid32, in_ready32, out_valid32, out_ready32, op_err32;
    logic [31:0] inst32, pc32, imm32, target32;
    logic [7:0]  op32;

    // XLEN = 64 instance
    logic        in_valid64, in_ready64, out_valid64, out_ready64, op_err64;
    logic [31:0] inst64;
    logic [63:0] pc64, imm64, target64;
    logic [7:0]  op64;

    int errors = 0;
    int checks = 0;

    exp_t q32[$];
    exp_t q64[$];
    exp_t nxt32;
    exp_t nxt64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .OP_W(8)) dut32 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid32),
        .in_ready (in_ready32),
        .inst     (inst32),
        .ext_op   (op32),
        .pc       (pc32),
        .out_valid(out_valid32),
        .out_ready(out_ready32),
        .imm      (imm32),
        .target   (target32),
        .op_err   (op_err32)
    );

    imm_gen_pipe #(.XLEN(64), .OP_W(8)) dut64 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid64),
        .in_ready (in_ready64),
        .inst     (inst64),
        .ext_op   (op64),
        .pc       (pc64),
        .out_valid(out_valid64),
        .out_ready(out_ready64),
        .imm      (imm64),
        .target   (target64),
        .op_err   (op_err64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction to the 32-bit instance. Record its expected result.
    task automatic drive32(input logic [31:0] i, input logic [7:0] op,
                           input logic [31:0] pc, input logic [31:0] e_imm,
                           input logic e_err);
        in_valid32   = 1'b1;
        inst32       = i;
        op32         = op;
        pc32         = pc;
        nxt32.imm    = {32'b0, e_imm};
        nxt32.target = {32'b0, pc + e_imm};
        nxt32.err    = e_err;
    endtask

    task automatic drive64(input logic [31:0] i, input logic [7:0] op,
                           input logic [63:0] pc, input logic [63:0] e_imm,
                           input logic e_err);
        in_valid64   = 1'b1;
        inst64       = i;
        op64         = op;
        pc64         = pc;
        nxt64.imm    = e_imm;
        nxt64.target = pc + e_imm;
        nxt64.err    = e_err;
    endtask

    // Sample the handshakes just before the edge: score pops and record pushes.
    // Then move on to the next falling edge, where new stimulus is applied.
    task automatic tick();
        bit   a32, p32, a64, p64;
        exp_t e;
        #1;
        a32 = in_valid32 && in_ready32 && !flush && !rst;
        p32 = out_valid32 && out_ready32 && !flush && !rst;
        a64 = in_valid64 && in_ready64 && !flush && !rst;
        p64 = out_valid64 && out_ready64 && !flush && !rst;
        if (p32) begin
            check("out32_expected", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check("imm32", {32'b0, imm32}, e.imm);
                check("target32", {32'b0, target32}, e.target);
                check("op_err32", 64'(op_err32), 64'(e.err));
            end
        end
        if (p64) begin
            check("out64_expected", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) begin
                e = q64.pop_front();
                check("imm64", imm64, e.imm);
                check("target64", target64, e.target);
                check("op_err64", 64'(op_err64), 64'(e.err));
            end
        end
        if (flush || rst) begin
            q32.delete();
            q64.delete();
        end else begin
            if (a32) q32.push_back(nxt32);
            if (a64) q64.push_back(nxt64);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid32  = 1'b0;
        inst32      = '0;
        op32        = '0;
        pc32        = '0;
        out_ready32 = 1'b1;
        in_valid64  = 1'b0;
        inst64      = '0;
        op64        = '0;
        pc64        = '0;
        out_ready64 = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid32", 64'(out_valid32), 64'd0);
        check("rst_imm32", {32'b0, imm32}, 64'd0);
        check("rst_target32", {32'b0, target32}, 64'd0);
        check("rst_op_err32", 64'(op_err32), 64'd0);
        check("rst_in_ready32", 64'(in_ready32), 64'd0);
        check("rst_out_valid64", 64'(out_valid64), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready32), 64'd1);

        // I then U, back to back, with 1-cycle latency
        drive32(32'hFFF00093, OP_I, 32'h0, 32'hFFFFFFFF, 1'b0);
        tick();
        check("latency_out_valid", 64'(out_valid32), 64'd1);
        drive32(32'h12345037, OP_U, 32'h0, 32'h12345000, 1'b0);
        tick();
        check("u_on_next_cycle", {32'b0, imm32}, 64'h12345000);

        // B, J, S, CSRZ, ISHAMT (XLEN=32) and illegal selects, streamed
        drive32(32'hFE000EE3, OP_B,  32'h100, 32'hFFFFFFFC, 1'b0); tick();
        drive32(32'hFF9FF06F, OP_J,  32'h8,   32'hFFFFFFF8, 1'b0); tick();
        drive32(32'hFE000FA3, OP_S,  32'h10,  32'hFFFFFFFF, 1'b0); tick();
        drive32(32'hFFFFFFFF, OP_CZ, 32'h0,   32'h0000001F, 1'b0); tick();
        drive32(32'h03F0D093, OP_SH, 32'h0,   32'h0000001F, 1'b0); tick();
        drive32(32'h12345678, 8'h00, 32'h40,  32'h0,        1'b1); tick();
        drive32(32'h12345678, 8'h11, 32'h40,  32'h0,        1'b1); tick();
        drive32(32'h12345678, 8'h80, 32'h40,  32'h0,        1'b1); tick();
        in_valid32 = 1'b0;
        tick();
        tick();

        // Backpressure: two entries absorbed, third held off until first pop
        out_ready32 = 1'b0;
        drive32(32'h00100093, OP_I, 32'h200, 32'h1, 1'b0); tick();
        drive32(32'h00200093, OP_I, 32'h200, 32'h2, 1'b0); tick();
        check("bp_in_ready_low", 64'(in_ready32), 64'd0);
        drive32(32'h00300093, OP_I, 32'h200, 32'h3, 1'b0); tick();
        check("bp_in_ready_still_low", 64'(in_ready32), 64'd0);
        check("bp_head_stable_a", {32'b0, imm32}, 64'h1);
        tick();
        check("bp_head_stable_b", {32'b0, imm32}, 64'h1);
        out_ready32 = 1'b1;
        tick();
        check("bp_ready_after_pop", 64'(in_ready32), 64'd1);
        tick();
        in_valid32 = 1'b0;
        tick();
        tick();
        check("bp_drained_valid", 64'(out_valid32), 64'd0);
        check("bp_all_delivered", 64'(q32.size()), 64'd0);

        // Flush from FULL with in_valid high
        out_ready32 = 1'b0;
        drive32(32'h00500093, OP_I, 32'h0, 32'h5, 1'b0); tick();
        drive32(32'h00600093, OP_I, 32'h0, 32'h6, 1'b0); tick();
        drive32(32'h00700093, OP_I, 32'h0, 32'h7, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid32 = 1'b0;
        check("flush_out_valid", 64'(out_valid32), 64'd0);
        check("flush_in_ready", 64'(in_ready32), 64'd1);
        // Flush from EMPTY while in_ready is high: the input is still dropped
        drive32(32'h00800093, OP_I, 32'h0, 32'h8, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid32 = 1'b0;
        check("flush_drops_input", 64'(out_valid32), 64'd0);
        out_ready32 = 1'b1;
        tick();
        tick();

        // Reset mid-stream
        out_ready32 = 1'b0;
        drive32(32'hFFF00093, OP_I, 32'h300, 32'hFFFFFFFF, 1'b0); tick();
        drive32(32'h80000037, OP_U, 32'h300, 32'h80000000, 1'b0); tick();
        drive32(32'h00900093, OP_I, 32'h0, 32'h9, 1'b0);
        rst = 1'b1;
        tick();
        in_valid32 = 1'b0;
        check("rst2_out_valid", 64'(out_valid32), 64'd0);
        check("rst2_imm", {32'b0, imm32}, 64'd0);
        check("rst2_target", {32'b0, target32}, 64'd0);
        check("rst2_op_err", 64'(op_err32), 64'd0);
        check("rst2_in_ready", 64'(in_ready32), 64'd0);
        rst = 1'b0;
        #1;
        check("rst2_in_ready_release", 64'(in_ready32), 64'd1);
        out_ready32 = 1'b1;
        tick();
        tick();

        // XLEN = 64
        drive64(32'h03F0D093, OP_SH, 64'h0, 64'h3F, 1'b0); tick();
        drive64(32'h80000013, OP_I,  64'h0, 64'hFFFFFFFFFFFFF800, 1'b0); tick();
        drive64(32'h80000037, OP_U,  64'h0, 64'hFFFFFFFF80000000, 1'b0); tick();
        drive64(32'h00000463, OP_B,  64'hFFFFFFFFFFFFFFFC, 64'h8, 1'b0); tick();
        drive64(32'h12345678, 8'h11, 64'h40, 64'h0, 1'b1); tick();
        in_valid64 = 1'b0;
        tick();
        check("wrap_target_head", target64, 64'h0000000000000040);
        tick();
        check("q64_all_delivered", 64'(q64.size()), 64'd0);
        check("q32_all_delivered", 64'(q32.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RISC-V core. Takes a raw instruction word, a one-hot format select and the instruction PC, and produces the sign/zero-extended immediate plus the PC-relative target `pc + imm` one cycle later. A 2-entry skid buffer with valid/ready handshakes on both sides lets it sit between decode and execute in the pipelined datapath. It also covers U-type, shift-amount and CSR-zimm formats and XLEN=64.

## Interface
- `XLEN`, 32: datapath width; legal values 32 and 64.
- `OP_W`, 8: width of the one-hot format select.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `flush`  input  1  synchronous pipeline flush; discards all buffered entries.
- `in_valid`  input  1  upstream offers an instruction.
- `in_ready`  output  1  block can accept; transfer when `in_valid && in_ready`.
- `inst`  input  32  raw instruction word.
- `ext_op`  input  OP_W  one-hot format select: bit0 J, bit1 U, bit2 B, bit3 S, bit4 I, bit5 ISHAMT, bit6 CSRZ, bit7 reserved.
- `pc`  input  XLEN  PC of the instruction.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  downstream accepts; transfer when `out_valid && out_ready`.
- `imm`  output  XLEN  extended immediate.
- `target`  output  XLEN  `pc + imm`, modulo 2^XLEN.
- `op_err`  output  1  `ext_op` was not exactly one of bits 0..6.

## Operation
- Extraction, where s() means sign-extend to XLEN and z() means zero-extend to XLEN:
  - I: s(inst[31:20]).
  - S: s({inst[31:25],inst[11:7]}).
  - B: s({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: s({inst[31:12],12'b0}).
  - J: s({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - ISHAMT: z(inst[25:20]) when XLEN=64, z(inst[24:20]) when XLEN=32.
  - CSRZ: z(inst[19:15]).
- `op_err` = 1 when `ext_op` is zero, has more than one bit set, or has bit7 set. In that case `imm` = 0 and `target` = `pc`.
- Immediate, target and error are computed combinationally at the input and captured into the buffer on accept. Outputs come from the head entry only.
- Buffer is a 2-entry FIFO with in-order delivery. Occupancy states: EMPTY, ONE, FULL.
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to FULL; pop without push goes to EMPTY; push with pop stays ONE, and the new entry becomes head.
  - FULL: pop goes to ONE. No push is possible because `in_ready` = 0.
- `in_ready` = (state != FULL). It is a registered decode of state, with no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY).
- Head data is stable while `out_valid && !out_ready`.
- `flush` has priority over push and pop. The next state is EMPTY, and any `in_valid` in the flush cycle is dropped.
- `rst` has priority over `flush`.

## Timing
- Reset values, visible the cycle after `rst` is sampled high: `out_valid` 0, `imm` 0, `target` 0, `op_err` 0, state EMPTY.
- `in_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
- Latency: input accepted at edge N, result on outputs with `out_valid` = 1 after edge N (1 cycle).
- Throughput: 1 per cycle while `out_ready` = 1.
- Backpressure: with `out_ready` = 0 the block absorbs 2 accepts, then `in_ready` drops in the cycle after the second accept.
- `in_ready` rises the cycle after the first pop from FULL.
- Reset or flush mid-stream: buffered entries are lost, with no partial output. `out_valid` = 0 the next cycle.
- Target addition wraps modulo 2^XLEN, with no overflow flag.

## Test plan
- I and U formats, XLEN=32: `inst` 0xFFF00093 with I, then 0x12345037 with U, `pc` 0x0, `out_ready` = 1.
  - Required: `imm` 0xFFFFFFFF then 0x12345000 on consecutive cycles, each 1 cycle after accept.
- B and J formats with targets:
  - 0xFE000EE3 with B at `pc` 0x100 -> `imm` 0xFFFFFFFC, `target` 0x000000FC.
  - 0xFF9FF06F with J at `pc` 0x8 -> `imm` 0xFFFFFFF8, `target` 0x0.
- Backpressure: hold `out_ready` = 0 and stream 3 valid inputs.
  - Required: 2 accepted, `in_ready` = 0 thereafter, head stable.
  - Then raise `out_ready`: results drain in order, and the 3rd input is accepted the cycle after the first pop.
- Flush: with FULL buffer and `in_valid` = 1, assert `flush` for 1 cycle.
  - Required: next cycle `out_valid` = 0, `in_ready` = 1, and the flush-cycle input is not delivered.
  - Repeat with `rst` and verify all outputs are 0.
- Illegal op: `ext_op` 0x00, 0x11 and 0x80 at `pc` 0x40.
  - Required: `op_err` = 1, `imm` 0, `target` 0x40.
  - Also `ext_op` 0x40 with `inst` 0xFFFFFFFF -> `imm` 0x1F, `op_err` 0.
- XLEN=64:
  - ISHAMT on 0x03F0D093 -> `imm` 0x3F.
  - I on 0x80000013 -> `imm` 0xFFFFFFFFFFFFF800.
  - U on 0x80000037 -> `imm` 0xFFFFFFFF80000000.
  - Target wrap: `pc` 0xFFFFFFFFFFFFFFFC, B with `imm` +8 -> `target` 0x4.
